// File: rtl/jstk_dir_filter.sv
// Joystick direction filter: classifies X/Y samples with hysteresis and debounces across frames.
// Latency: a new direction commits on the edge that registers the STABLE_N-th agreeing sample.
// Backpressure: none; the block only advances on sample_valid and holds state otherwise.
//
// Ports:
//   CLK          system clock
//   RST          synchronous active-high reset (priority over sample_valid)
//   sample_valid one-cycle strobe, x_pos/y_pos carry a new frame
//   x_pos/y_pos  unsigned joystick position, POS_W bits
//   dir          committed direction (0 NONE, 1 UP, 2 DOWN, 3 RIGHT, 4 LEFT)
//   dir_pulse    one-cycle strobe on each commit (and on each repeat when enabled)
//   last_dir     last committed non-NONE direction
//   pending      high while a candidate differing from dir is being counted
//
// Optional feature: define JSTK_DIR_REPEAT_EN to emit a repeat pulse every
// REPEAT_N agreeing samples while a non-NONE direction is held.
module jstk_dir_filter #(
    parameter int POS_W    = 10,
    parameter int HI_TH    = 800,
    parameter int LO_TH    = 200,
    parameter int HYST     = 32,
    parameter int STABLE_N = 3,
    parameter int REPEAT_N = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             sample_valid,
    input  logic [POS_W-1:0] x_pos,
    input  logic [POS_W-1:0] y_pos,
    output logic [2:0]       dir,
    output logic             dir_pulse,
    output logic [2:0]       last_dir,
    output logic             pending
);

    localparam int CNT_W = $clog2(STABLE_N + 1);

    localparam logic [POS_W-1:0] C_HI     = POS_W'(HI_TH);
    localparam logic [POS_W-1:0] C_LO     = POS_W'(LO_TH);
    localparam logic [POS_W-1:0] C_HI_RET = POS_W'(HI_TH - HYST);
    localparam logic [POS_W-1:0] C_LO_RET = POS_W'(LO_TH + HYST);
    localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_N);

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_RIGHT = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_dir, w_dir_nxt;
    logic [2:0]       r_last_dir, w_last_nxt;
    logic [2:0]       r_cand, w_cand_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_pulse, w_pulse_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_commit;
    logic             w_retain;
    logic [2:0]       w_raw;

`ifdef JSTK_DIR_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_N + 1);
    localparam logic [REP_W-1:0] C_REPEAT = REP_W'(REPEAT_N);
    logic [REP_W-1:0] r_rep, w_rep_nxt, w_rep_inc;
    assign w_rep_inc = r_rep + REP_W'(1);
`endif

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Raw classification. The currently committed direction is retained with
    // the relaxed (hysteresis) threshold before the entry thresholds apply.
    always_comb begin
        w_retain = 1'b0;
        case (r_dir)
            DIR_UP:    w_retain = (y_pos > C_HI_RET);
            DIR_DOWN:  w_retain = (y_pos < C_LO_RET);
            DIR_RIGHT: w_retain = (x_pos > C_HI_RET);
            DIR_LEFT:  w_retain = (x_pos < C_LO_RET);
            default:   w_retain = 1'b0;
        endcase

        w_raw = DIR_NONE;
        if (w_retain)          w_raw = r_dir;
        else if (y_pos > C_HI) w_raw = DIR_UP;
        else if (y_pos < C_LO) w_raw = DIR_DOWN;
        else if (x_pos > C_HI) w_raw = DIR_RIGHT;
        else if (x_pos < C_LO) w_raw = DIR_LEFT;
    end

    // Debounce FSM: next-state and output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_last_nxt  = r_last_dir;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        w_commit    = 1'b0;
`ifdef JSTK_DIR_REPEAT_EN
        w_rep_nxt   = r_rep;
`endif

        if (sample_valid) begin
            case (r_state)
                ST_STABLE: begin
                    if (w_raw != r_dir) begin
                        w_cand_nxt = w_raw;
                        w_cnt_nxt  = CNT_W'(1);
`ifdef JSTK_DIR_REPEAT_EN
                        w_rep_nxt  = '0;
`endif
                        if (STABLE_N == 1) w_commit = 1'b1;
                        else               w_state_nxt = ST_PENDING;
                    end
`ifdef JSTK_DIR_REPEAT_EN
                    else if (r_dir == DIR_NONE) begin
                        w_rep_nxt = '0;
                    end else if (w_rep_inc == C_REPEAT) begin
                        w_rep_nxt   = '0;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_rep_nxt = w_rep_inc;
                    end
`endif
                end
                ST_PENDING: begin
                    if (w_raw == r_dir) begin
                        // Candidate abandoned: the stick went back.
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else if (w_raw == r_cand) begin
                        if (w_cnt_inc == C_STABLE) w_commit  = 1'b1;
                        else                       w_cnt_nxt = w_cnt_inc;
                    end else begin
                        // A different candidate restarts the count.
                        w_cand_nxt = w_raw;
                        w_cnt_nxt  = CNT_W'(1);
                        if (STABLE_N == 1) w_commit = 1'b1;
                    end
                end
                default: w_state_nxt = ST_STABLE;
            endcase

            if (w_commit) begin
                w_dir_nxt   = w_cand_nxt;
                w_pulse_nxt = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
                if (w_cand_nxt != DIR_NONE) w_last_nxt = w_cand_nxt;
`ifdef JSTK_DIR_REPEAT_EN
                w_rep_nxt   = '0;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_STABLE;
            r_dir      <= DIR_NONE;
            r_last_dir <= DIR_NONE;
            r_cand     <= DIR_NONE;
            r_cnt      <= '0;
            r_pulse    <= 1'b0;
`ifdef JSTK_DIR_REPEAT_EN
            r_rep      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_last_dir <= w_last_nxt;
            r_cand     <= w_cand_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pulse    <= w_pulse_nxt;
`ifdef JSTK_DIR_REPEAT_EN
            r_rep      <= w_rep_nxt;
`endif
        end
    end

    assign dir       = r_dir;
    assign dir_pulse = r_pulse;
    assign last_dir  = r_last_dir;
    assign pending   = (r_state == ST_PENDING);

endmodule

// File: tb/tb_jstk_dir_filter.sv
// Bench for jstk_dir_filter: directed scenarios, then randomized frames,
// every cycle compared against a run-length reference model.
module tb_jstk_dir_filter;

    localparam int POS_W    = 10;
    localparam int HI_TH    = 800;
    localparam int LO_TH    = 200;
    localparam int HYST     = 32;
    localparam int STABLE_N = 3;
    localparam int REPEAT_N = 5;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             sample_valid = 1'b0;
    logic [POS_W-1:0] x_pos = '0;
    logic [POS_W-1:0] y_pos = '0;
    logic [2:0]       dir;
    logic             dir_pulse;
    logic [2:0]       last_dir;
    logic             pending;

    jstk_dir_filter #(
        .POS_W(POS_W), .HI_TH(HI_TH), .LO_TH(LO_TH), .HYST(HYST),
        .STABLE_N(STABLE_N), .REPEAT_N(REPEAT_N)
    ) dut (
        .CLK(CLK), .RST(RST), .sample_valid(sample_valid),
        .x_pos(x_pos), .y_pos(y_pos),
        .dir(dir), .dir_pulse(dir_pulse), .last_dir(last_dir), .pending(pending)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: committed direction plus the length of the current
    // run of identical raw values that differ from the committed direction.
    int m_dir = 0, m_last = 0, m_pulse = 0;
    int m_run_val = 0, m_run_len = 0;
    int m_hold = 0;

    function automatic int classify(int x, int y, int cur);
        if (cur == 1 && y > HI_TH - HYST) return 1;
        if (cur == 2 && y < LO_TH + HYST) return 2;
        if (cur == 3 && x > HI_TH - HYST) return 3;
        if (cur == 4 && x < LO_TH + HYST) return 4;
        if (y > HI_TH) return 1;
        if (y < LO_TH) return 2;
        if (x > HI_TH) return 3;
        if (x < LO_TH) return 4;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst, input logic sv, input int x, input int y);
        int raw;
        if (rst) begin
            m_dir = 0; m_last = 0; m_pulse = 0;
            m_run_val = 0; m_run_len = 0; m_hold = 0;
        end else if (!sv) begin
            m_pulse = 0;
        end else begin
            m_pulse = 0;
            raw = classify(x, y, m_dir);
            if (raw == m_dir) begin
                if (m_run_len == 0 && m_dir != 0) begin
                    m_hold++;
`ifdef JSTK_DIR_REPEAT_EN
                    if (m_hold == REPEAT_N) begin
                        m_pulse = 1;
                        m_hold = 0;
                    end
`endif
                end
                m_run_len = 0;
            end else begin
                if (m_run_len > 0 && raw == m_run_val) m_run_len++;
                else begin
                    m_run_val = raw;
                    m_run_len = 1;
                end
                m_hold = 0;
                if (m_run_len == STABLE_N) begin
                    m_dir = raw;
                    m_pulse = 1;
                    if (raw != 0) m_last = raw;
                    m_run_len = 0;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input logic rst, input logic sv, input int x, input int y);
        RST = rst;
        sample_valid = sv;
        x_pos = POS_W'(x);
        y_pos = POS_W'(y);
        model_update(rst, sv, x, y);
        @(posedge CLK);
        #1;
        check("dir", int'(dir), m_dir);
        check("dir_pulse", int'(dir_pulse), m_pulse);
        check("last_dir", int'(last_dir), m_last);
        check("pending", int'(pending), (m_run_len > 0) ? 1 : 0);
    endtask

    function automatic int rand_pos();
        case ($urandom_range(0, 5))
            0: return $urandom_range(HI_TH - HYST - 4, HI_TH + 4);
            1: return $urandom_range(LO_TH - 4, LO_TH + HYST + 4);
            2: return $urandom_range(400, 600);
            3: return $urandom_range(0, 1023);
            4: return $urandom_range(900, 1023);
            default: return $urandom_range(0, 150);
        endcase
    endfunction

    initial begin
        int pulses;
        int rx, ry;

        // 1: reset, then three UP frames commit on the third.
        step(1, 0, 512, 512);
        check("reset_dir", int'(dir), 0);
        check("reset_pending", int'(pending), 0);
        step(0, 1, 512, 900);
        step(0, 1, 512, 900);
        check("t1_not_yet", int'(dir), 0);
        step(0, 1, 512, 900);
        check("t1_dir", int'(dir), 1);
        check("t1_pulse", int'(dir_pulse), 1);
        check("t1_last", int'(last_dir), 1);
        step(0, 0, 0, 0);
        check("t1_hold_dir", int'(dir), 1);
        check("t1_hold_pulse", int'(dir_pulse), 0);

        // 2: a glitch sample restarts the count.
        step(1, 0, 512, 512);
        step(0, 1, 512, 900);
        step(0, 1, 512, 512);
        step(0, 1, 512, 900);
        step(0, 1, 512, 900);
        check("t2_no_commit", int'(dir), 0);
        check("t2_pending", int'(pending), 1);
        step(0, 1, 512, 900);
        check("t2_commit", int'(dir), 1);

        // 3: hysteresis keeps UP at 780, releases at 760.
        repeat (5) step(0, 1, 512, 780);
        check("t3_retain", int'(dir), 1);
        repeat (3) step(0, 1, 512, 760);
        check("t3_release", int'(dir), 0);
        check("t3_pulse", int'(dir_pulse), 1);
        check("t3_last", int'(last_dir), 1);

        // 4: Y axis beats X axis, then RIGHT.
        repeat (3) step(0, 1, 900, 100);
        check("t4_down", int'(dir), 2);
        repeat (3) step(0, 1, 900, 512);
        check("t4_right", int'(dir), 3);
        check("t4_last", int'(last_dir), 3);

        // 5: reset mid-pending discards the count.
        step(1, 0, 512, 512);
        repeat (2) step(0, 1, 512, 900);
        check("t5_pending", int'(pending), 1);
        step(1, 1, 512, 900);
        check("t5_rst_pending", int'(pending), 0);
        check("t5_rst_dir", int'(dir), 0);
        repeat (2) step(0, 1, 512, 900);
        check("t5_no_commit", int'(dir), 0);
        step(0, 1, 512, 900);
        check("t5_commit", int'(dir), 1);

        // 6: 13 held UP frames.
        step(1, 0, 512, 512);
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            step(0, 1, 512, 900);
            if (dir_pulse) pulses++;
        end
`ifdef JSTK_DIR_REPEAT_EN
        check("t6_pulses", pulses, 3);
`else
        check("t6_pulses", pulses, 1);
`endif

        // Randomized frames; positions are often held to let commits happen.
        rx = 512; ry = 512;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx = rand_pos();
                ry = rand_pos();
            end
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, rx, ry);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jstk_dir_filter.md
Name: jstk_dir_filter

Overview:
- Parametrised successor to the fixed-threshold joystick direction decode.
- Takes X/Y position samples from the PmodJSTK SPI interface, one `sample_valid` pulse per frame.
- Classifies each sample into UP/DOWN/RIGHT/LEFT/NONE using configurable thresholds with hysteresis, and debounces across consecutive samples.
- Outputs a registered direction, a change pulse, and a sticky last-non-neutral direction for the game movement logic.

Parameters:
POS_W, 10, width of x_pos/y_pos (unsigned)
HI_TH, 800, entry threshold for UP (Y) / RIGHT (X); raw > HI_TH
LO_TH, 200, entry threshold for DOWN (Y) / LEFT (X); raw < LO_TH
HYST, 32, hysteresis band; must be < (HI_TH-LO_TH)/2
STABLE_N, 3, consecutive agreeing samples required to commit a new direction; >= 1
REPEAT_N, 5, samples between repeat pulses (used only with JSTK_DIR_REPEAT_EN); >= 1

Ports:
CLK  in  1  system clock (100 MHz)
RST  in  1  synchronous reset, active-high
sample_valid  in  1  one-cycle strobe: x_pos/y_pos hold a new frame
x_pos  in  POS_W  joystick X position
y_pos  in  POS_W  joystick Y position
dir  out  3  committed direction: 0 NONE, 1 UP, 2 DOWN, 3 RIGHT, 4 LEFT
dir_pulse  out  1  one-cycle strobe on each commit (or repeat)
last_dir  out  3  last committed non-NONE direction; never returns to 0 except on reset
pending  out  1  high while a candidate differing from dir is being counted

Behaviour:
- Reset (RST=1 at CLK edge): dir=0, last_dir=0, dir_pulse=0, pending=0, cand=0, cnt=0, rep=0. RST has priority over sample_valid in the same cycle.
- All state changes occur only on cycles with sample_valid=1; otherwise every register holds, and dir_pulse is forced 0.
- Raw classification (combinational, per sample):
  - Retention first: if dir=UP and y > HI_TH-HYST, raw=UP. Same rule for the other directions: DOWN if y < LO_TH+HYST; RIGHT if x > HI_TH-HYST; LEFT if x < LO_TH+HYST.
  - Otherwise use the fixed priority with entry thresholds: y>HI_TH → UP, y<LO_TH → DOWN, x>HI_TH → RIGHT, x<LO_TH → LEFT, else NONE.
  - Comparisons are strict and unsigned. Constants are sized to POS_W.
- FSM, two states:
  - ST_STABLE (pending=0): on a sample with raw==dir, stay. On raw!=dir: cand=raw, cnt=1. If STABLE_N==1, commit immediately; otherwise go to ST_PENDING.
  - ST_PENDING (pending=1):
    - raw==dir: abandon, cnt=0, go to ST_STABLE, no pulse.
    - raw==cand: cnt+1. When cnt+1==STABLE_N, commit and go to ST_STABLE.
    - raw is another direction: cand=raw, cnt=1, stay in ST_PENDING.
- Commit: dir<=cand and dir_pulse=1 for exactly one cycle, both visible on the edge that registers the STABLE_N-th agreeing sample. last_dir<=cand only if cand!=0. cnt and rep are cleared.
- Commit to NONE (stick released) also pulses dir_pulse; last_dir is unchanged.
- cnt width is clog2(STABLE_N+1) and never exceeds STABLE_N.
- Reset mid-pending discards cand and cnt. The first post-reset sample starts counting from 1.

Optional Feature:
- Macro: JSTK_DIR_REPEAT_EN.
- Defined: in ST_STABLE with dir!=0, each sample_valid with raw==dir increments rep. When rep reaches REPEAT_N, dir_pulse=1 for one cycle and rep=0. rep is cleared on commit, on leaving ST_STABLE, and when dir=0.
- Undefined: rep logic is absent; dir_pulse fires only on commits.

Test Plan:
1. Reset, then 3 samples (x=512, y=900) → dir=1 and dir_pulse=1 on the edge of the 3rd sample, last_dir=1, pending=0 afterwards. With no sample_valid, the outputs hold.
2. dir=0; samples y=900, y=512, y=900, y=900 → no commit (the glitch resets the count). The next y=900 sample commits UP on the 3rd consecutive agreeing sample.
3. Hysteresis: dir=UP; samples y=780 x5 → dir stays 1. Samples y=760 x3 → dir=0 with a pulse, last_dir stays 1.
4. Priority: dir=0; samples x=900, y=100 x3 → dir=2 (Y axis wins). Then x=900, y=512 x3 → dir=3, last_dir=3.
5. Assert RST during ST_PENDING (cnt=2) → all outputs 0 next cycle. 2 subsequent UP samples give no commit; the 3rd commits.
6. With JSTK_DIR_REPEAT_EN, REPEAT_N=5: hold y=900 for 13 samples → pulses at samples 3, 8 and 13. Without the macro → a single pulse at sample 3.
